plot_scheduler: RTL and testbench
=================================

# plot_scheduler

Sequences and shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter between NUM_REQ drawing engines and a built-in full-screen clear engine. Sits between the drawing state machines and the adapter's x/y/colour/plot inputs in the top level. Requester access is round-robin, and a clear request preempts all requesters. Every adapter write is registered and issued at a rate of one pixel per clock.

## Interface
Parameters:
- NUM_REQ, 3: number of drawing requesters (2..8).
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- X_MAX, 159: last valid column.
- Y_MAX, 119: last valid row.
- COLOUR_W, 3: colour width.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester pixel request; held high with data stable until granted.
- req_x  in  NUM_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y, same packing.
- req_colour  in  NUM_REQ*COLOUR_W  packed colour, same packing.
- grant  out  NUM_REQ  one-hot, one-cycle acknowledge that the request was consumed.
- clear_req  in  1  start a full-screen clear.
- clear_colour  in  COLOUR_W  fill colour, sampled when the clear starts.
- clear_busy  out  1  high while a clear is in progress.
- vga_x  out  X_W  to adapter x.
- vga_y  out  Y_W  to adapter y.
- vga_colour  out  COLOUR_W  to adapter colour.
- vga_plot  out  1  to adapter plot (write enable).

## Operation
- States:
  - ARB: serve requesters.
  - CLEAR: sweep the screen.
- Reset values:
  - State ARB; all outputs 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Clear counters 0.
- ARB, at each edge:
  - If clear_req=1: go to CLEAR. Latch clear_colour. Counters cx=0, cy=0. No grant this edge.
  - Otherwise, eligible = req & ~grant. The ~grant term masks a requester during its own grant cycle, so one request is never granted twice.
  - The winner is the first eligible index searching upward from pointer+1, wrapping at NUM_REQ.
  - On a win: register the winner's x, y and colour into vga_*. Set vga_plot=1 and grant[winner]=1. Pointer := winner.
  - No eligible requester: vga_plot=0 and grant=0. vga_x, vga_y and vga_colour hold.
- Out-of-range request (x>X_MAX or y>Y_MAX): grant is still issued, but vga_plot=0 for that cycle, so the pixel is dropped.
- CLEAR, at each edge:
  - Drive vga_x=cx, vga_y=cy, vga_colour=latched colour, vga_plot=1. grant stays 0.
  - Sweep is row-major: cx increments; at X_MAX, cx wraps to 0 and cy increments.
  - After issuing (X_MAX,Y_MAX), return to ARB. Counters reset to 0.
  - clear_req is ignored while in CLEAR; it is not queued.
- clear_busy = 1 in exactly the cycles where vga_plot carries a clear pixel.
- Requests arriving during CLEAR stall, with no grant, and are arbitrated normally after it.

## Timing
- Latency: a request sampled at edge n gives grant and vga_plot high during cycle n..n+1. The requester may change its data or drop req at edge n+1.
- Throughput:
  - One pixel per cycle in aggregate.
  - A single requester holding req continuously is granted every other cycle, because of the grant mask.
  - With two or more requesters active, the adapter sees a write every cycle.
- Clear:
  - Lasts exactly (X_MAX+1)*(Y_MAX+1) = 19200 cycles of vga_plot=1.
  - Requester arbitration resumes at the edge after the last clear pixel.
- Simultaneous clear_req and req in ARB: the clear wins. The requester is granted after the clear completes.
- Reset asserted mid-operation: asynchronous return to the reset values, including mid-clear. The clear is abandoned, and grant and vga_plot drop immediately.

## Structure
- Package plot_pkg holds:
  - X_W, Y_W, X_MAX, Y_MAX, COLOUR_W.
  - The state enum {ARB, CLEAR}.
  - Screen-size constant SCREEN_PIXELS = 19200.
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot winner and a valid flag.
  - Combinational; the pointer register lives in plot_scheduler.
- The clear counters, the state register and the output registers live in plot_scheduler.

## Test plan
- Reset then single request: req[0]=1, x=10, y=20, colour=5.
  - Required: grant=001 and vga_plot=1 with (10,20,5) one cycle after sampling.
  - Holding req continuously gives grants on alternate cycles only.
- Fairness: all three req held high.
  - Required: grants in order 0,1,2,0,1,2…; vga_plot high every cycle; no requester granted twice in a row.
- Clear: pulse clear_req with clear_colour=2.
  - Required: clear_busy high for exactly 19200 cycles.
  - Required: first write (0,0), write 160 is (0,1), last write (159,119), all colour 2, grant=0 throughout.
- Clear contention: clear_req and req[1] rise at the same edge.
  - Required: the clear starts.
  - Required: req[1] is granted on the first cycle after the clear ends.
  - Required: a second clear_req pulse mid-clear has no effect.
- Out of range: req[2] with x=160, y=0.
  - Required: grant[2] pulses and vga_plot stays 0.
  - Required: a following request at y=119, x=159 plots normally.
- Mid-clear reset: assert resetn=0 at clear pixel 5000.
  - Required: vga_plot, clear_busy and grant are 0 immediately.
  - Required: after release, a req[0] is served with requester 0 as first priority.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared constants, state encoding and helpers for the pixel-write scheduler.
package plot_pkg;

    // 160x120 screen, 3-bit colour
    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int X_MAX         = 159;
    localparam int Y_MAX         = 119;
    localparam int COLOUR_W      = 3;
    localparam int SCREEN_PIXELS = (X_MAX + 1) * (Y_MAX + 1);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Modulo-n increment used to walk the round-robin ring.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after ptr,
// wrapping at NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);
    import plot_pkg::*;

    int               idx;
    logic [PTR_W-1:0] sel;

    // Walk the ring once starting after ptr; the first hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = int'(ptr);
        sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = wrap_inc(idx, NUM_REQ);
            sel = PTR_W'(idx);
            if (!valid && eligible[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the VGA adapter pixel-write port between NUM_REQ round-robin
// drawing requesters and a built-in full-screen clear that preempts them.
// Every adapter write is registered; one pixel per clock at most.
module plot_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = plot_pkg::X_W,
    parameter int Y_W      = plot_pkg::Y_W,
    parameter int X_MAX    = plot_pkg::X_MAX,
    parameter int Y_MAX    = plot_pkg::Y_MAX,
    parameter int COLOUR_W = plot_pkg::COLOUR_W
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           grant,
    input  logic                         clear_req,
    input  logic [COLOUR_W-1:0]          clear_colour,
    output logic                         clear_busy,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot
);
    import plot_pkg::*;

    localparam int               PTR_W  = $clog2(NUM_REQ);
    localparam logic [X_W-1:0]   X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(Y_MAX);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Per-requester view of the packed request buses
    pixel_t req_pix [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_pix[i] = {req_x[i*X_W +: X_W],
                             req_y[i*Y_W +: Y_W],
                             req_colour[i*COLOUR_W +: COLOUR_W]};
    end

    state_t               state, state_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [X_W-1:0]       cx, cx_n;
    logic [Y_W-1:0]       cy, cy_n;
    logic [COLOUR_W-1:0]  fill, fill_n;
    pixel_t               pix, pix_n;
    logic                 plot, plot_n;
    logic                 busy_n;
    logic [NUM_REQ-1:0]   grant_n;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   winner;
    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx;
    pixel_t               win_pix;
    logic                 in_range;

    // A requester is masked during its own grant cycle so a held request
    // is never consumed twice.
    assign eligible = req & ~grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .valid    (win_valid)
    );

    // One-hot winner to index, used for data select and the new pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (winner[i]) win_idx = PTR_W'(i);
    end

    assign win_pix  = req_pix[win_idx];
    assign in_range = (win_pix.x <= X_LAST) && (win_pix.y <= Y_LAST);

    // Next-state and next-output decode for ARB/CLEAR.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cx_n    = cx;
        cy_n    = cy;
        fill_n  = fill;
        pix_n   = pix;
        plot_n  = 1'b0;
        busy_n  = 1'b0;
        grant_n = '0;
        case (state)
            ARB: begin
                if (clear_req) begin
                    // Clear preempts; no grant on the entry edge.
                    state_n = CLEAR;
                    fill_n  = clear_colour;
                    cx_n    = '0;
                    cy_n    = '0;
                end else if (win_valid) begin
                    // Out-of-range pixels are acknowledged but not written.
                    pix_n   = win_pix;
                    plot_n  = in_range;
                    grant_n = winner;
                    ptr_n   = win_idx;
                end
            end
            CLEAR: begin
                pix_n  = {cx, cy, fill};
                plot_n = 1'b1;
                busy_n = 1'b1;
                if (cx == X_LAST) begin
                    cx_n = '0;
                    if (cy == Y_LAST) begin
                        cy_n    = '0;
                        state_n = ARB;
                    end else begin
                        cy_n = cy + Y_W'(1);
                    end
                end else begin
                    cx_n = cx + X_W'(1);
                end
            end
            default: state_n = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ARB;
        else         state <= state_n;
    end

    // Pointer, clear counters and the registered adapter outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr        <= PTR_RST;
            cx         <= '0;
            cy         <= '0;
            fill       <= '0;
            pix        <= '0;
            plot       <= 1'b0;
            clear_busy <= 1'b0;
            grant      <= '0;
        end else begin
            ptr        <= ptr_n;
            cx         <= cx_n;
            cy         <= cy_n;
            fill       <= fill_n;
            pix        <= pix_n;
            plot       <= plot_n;
            clear_busy <= busy_n;
            grant      <= grant_n;
        end
    end

    assign vga_x      = pix.x;
    assign vga_y      = pix.y;
    assign vga_colour = pix.colour;
    assign vga_plot   = plot;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed + random bench for plot_scheduler against a behavioural model
// that tracks pending requests, the last winner and a linear clear index.
module tb_plot_scheduler;

    localparam int N      = 3;
    localparam int XW     = 8;
    localparam int YW     = 7;
    localparam int CW     = 3;
    localparam int SCREEN = 160 * 120;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req;
    logic [N*XW-1:0]   req_x;
    logic [N*YW-1:0]   req_y;
    logic [N*CW-1:0]   req_colour;
    logic [N-1:0]      grant;
    logic              clear_req;
    logic [CW-1:0]     clear_colour;
    logic              clear_busy;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit        m_clear;
    int        m_k;
    int        m_fill;
    int        m_ptr;
    logic [N-1:0] m_grant;
    int        m_x, m_y, m_c;
    bit        m_plot, m_busy;

    plot_scheduler #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .grant        (grant),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 0; m_k = 0; m_fill = 0; m_ptr = N - 1; m_grant = '0;
        m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_busy = 0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic predict();
        logic [N-1:0] elig;
        int w, c;
        if (m_clear) begin
            m_x = m_k % 160; m_y = m_k / 160; m_c = m_fill;
            m_plot = 1; m_busy = 1; m_grant = '0;
            m_k++;
            if (m_k == SCREEN) begin m_clear = 0; m_k = 0; end
        end else if (clear_req) begin
            m_clear = 1; m_k = 0; m_fill = int'(clear_colour);
            m_grant = '0; m_plot = 0; m_busy = 0;
        end else begin
            elig = req & ~m_grant;
            w = -1;
            for (int s = 1; s <= N; s++) begin
                c = (m_ptr + s) % N;
                if (w < 0 && elig[c]) w = c;
            end
            m_busy = 0;
            m_grant = '0;
            if (w >= 0) begin
                m_x = int'(req_x[w*XW +: XW]);
                m_y = int'(req_y[w*YW +: YW]);
                m_c = int'(req_colour[w*CW +: CW]);
                m_grant[w] = 1'b1;
                m_plot = (m_x <= 159) && (m_y <= 119);
                m_ptr = w;
            end else begin
                m_plot = 0;
            end
        end
    endtask

    task automatic compare();
        chk("grant", 32'(grant), 32'(m_grant));
        chk("plot", 32'(vga_plot), 32'(m_plot));
        chk("busy", 32'(clear_busy), 32'(m_busy));
        chk("x", 32'(vga_x), m_x);
        chk("y", 32'(vga_y), m_y);
        chk("colour", 32'(vga_colour), m_c);
    endtask

    task automatic cyc();
        predict();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req[i] = 1'b1;
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req_colour[i*CW +: CW] = CW'(c);
    endtask

    task automatic drop_req(input int i);
        req[i] = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic [N-1:0] prev;

        resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_colour = '0;
        clear_req = 1'b0; clear_colour = '0;
        model_reset();
        #2;
        compare();
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single request, then held continuously
        set_req(0, 10, 20, 5);
        cyc();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_pix", {vga_plot, 8'(vga_x), 8'(vga_y), 8'(vga_colour)}, {1'b1, 8'd10, 8'd20, 8'd5});
        cyc();
        chk("hold_gap", 32'(grant), 32'h0);
        cyc();
        chk("hold_regrant", 32'(grant), 32'h1);
        repeat (3) cyc();
        drop_req(0);
        cyc();

        // Fairness: all three held
        set_req(0, 1, 2, 1); set_req(1, 3, 4, 2); set_req(2, 5, 6, 3);
        prev = '0;
        for (int n = 0; n < 12; n++) begin
            cyc();
            chk("no_repeat", 32'(grant & prev), 32'h0);
            chk("fair_plot", 32'(vga_plot), 32'h1);
            prev = grant;
        end
        drop_req(0); drop_req(1); drop_req(2);
        cyc();

        // Full clear in colour 2
        clear_req = 1'b1; clear_colour = 3'd2;
        cyc();
        clear_req = 1'b0;
        busy_cnt = 0;
        for (int n = 0; n < SCREEN + 2; n++) begin
            cyc();
            if (clear_busy) busy_cnt++;
        end
        chk("clear_len", busy_cnt, SCREEN);

        // Clear contention with req[1], plus an ignored mid-clear pulse
        set_req(1, 30, 40, 6);
        clear_req = 1'b1; clear_colour = 3'd4;
        cyc();
        chk("contention_nogrant", 32'(grant), 32'h0);
        clear_req = 1'b0;
        repeat (3000) cyc();
        clear_req = 1'b1; clear_colour = 3'd7;
        cyc();
        clear_req = 1'b0;
        for (int n = 0; n < 20000 && m_clear; n++) cyc();
        chk("clear_done_bound", 32'(m_clear), 32'h0);
        cyc();
        chk("contention_grant", 32'(grant), 32'h2);
        drop_req(1);
        cyc();

        // Out of range then corner pixel
        set_req(2, 160, 0, 3);
        cyc();
        chk("oor_grant", 32'(grant), 32'h4);
        chk("oor_plot", 32'(vga_plot), 32'h0);
        set_req(2, 159, 119, 6);
        cyc();
        cyc();
        chk("corner_plot", {vga_plot, 8'(vga_x), 8'(vga_y)}, {1'b1, 8'd159, 8'd119});
        drop_req(2);
        cyc();

        // Random requester traffic
        for (int n = 0; n < 400; n++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (m_grant[i]) begin
                    if ($urandom_range(1, 0) == 0) drop_req(i);
                    else set_req(i, $urandom_range(170, 0), $urandom_range(125, 0), $urandom_range(7, 0));
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    set_req(i, $urandom_range(170, 0), $urandom_range(125, 0), $urandom_range(7, 0));
                end
            end
        end
        req = '0;
        cyc();

        // Reset in the middle of a clear
        clear_req = 1'b1; clear_colour = 3'd5;
        cyc();
        clear_req = 1'b0;
        repeat (5000) cyc();
        #1 resetn = 1'b0;
        model_reset();
        #1;
        compare();
        #1 resetn = 1'b1;
        set_req(0, 7, 8, 1); set_req(1, 9, 10, 2); set_req(2, 11, 12, 3);
        cyc();
        chk("post_reset_prio", 32'(grant), 32'h1);
        req = '0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
